cla_multiword_seq: RTL
======================

// Module: cla_multiword_seq
// PURPOSE
//  Sequencer that reuses one WIDTH-bit cla_adder slice over WORDS clock cycles to add or
//  subtract two WIDTH*WORDS-bit operands, least-significant slice first, chaining the carry
//  in a register between cycles. Trades latency for area in the datapath; sits between an
//  operand producer and a result consumer, with a valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH  4  bits per adder slice (cla_adder width)
//  WORDS  4  slices per operand; legal range >= 1; total operand width N = WIDTH*WORDS
// PORTS
//  clk        in   1  single clock, all state updates on rising edge
//  rst_n      in   1  synchronous reset, active low
//  in_valid   in   1  operands a, b and sub are valid
//  in_ready   out  1  block accepts operands (high only in IDLE)
//  a          in   N  operand A (two's complement or unsigned)
//  b          in   N  operand B
//  sub        in   1  0: A+B; 1: A-B (computed as A + ~B + 1)
//  out_valid  out  1  sum, c_out and ovf are valid (high only in DONE)
//  out_ready  in   1  consumer accepts the result
//  sum        out  N  result
//  c_out      out  1  carry out of the MSB (for sub: 1 = no borrow)
//  ovf        out  1  signed overflow
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE; in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0,
//    slice index=0, carry reg=0. Overrides every other input, incl. mid-RUN/mid-DONE;
//    an in-flight operation is discarded and never produces out_valid.
//  - IDLE: in_ready=1. Edge with in_valid=1 latches a_reg=a, b_reg=(sub ? ~b : b),
//    carry=sub, idx=0, clears the result reg -> RUN. in_valid=0: stay.
//  - RUN: in_ready=0, out_valid=0. Each cycle cla_adder gets a_reg[idx], b_reg[idx], carry;
//    at the edge, sum slice idx <= adder sum, carry <= adder c_out, idx <= idx+1.
//    When idx==WORDS-1 the edge also captures c_out and ovf -> DONE. Exactly WORDS cycles.
//  - ovf = (a_reg MSB == b_reg MSB) && (sum MSB != a_reg MSB), using the effective
//    (possibly inverted) B.
//  - DONE: out_valid=1; sum/c_out/ovf held stable until out_ready=1 at an edge -> IDLE.
//    in_ready=0, so in_valid is ignored in RUN and DONE (no same-cycle restart).
//  - Latency: operands accepted at edge 0 -> out_valid high after edge WORDS.
//    Throughput: WORDS+2 cycles/op with out_ready tied high.
//  - WORDS=1: RUN lasts one cycle. idx width = max(1, clog2(WORDS)); idx never exceeds
//    WORDS-1 (no wrap). Outputs sum/c_out/ovf hold last result in IDLE until next accept.
//  - All arithmetic is modulo 2^N; carry out of the top slice is reported only via c_out.
// STRUCTURE
//  - Shared package cla_seq_pkg: state codes ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2,
//    state width constant; unused code 2'd3 decodes to IDLE.
//  - One sub-module: cla_adder #(.width(WIDTH)) for the slice; no other sub-modules.
//  - Slice select/insert by indexed part-select on a_reg, b_reg and result reg.
// TESTING  (WIDTH=4, WORDS=4, N=16 unless noted)
//  1. a=16'h00FF, b=16'h0001, sub=0 -> sum=16'h0100, c_out=0, ovf=0, out_valid after edge 4.
//  2. a=16'hFFFF, b=16'h0001, sub=0 -> sum=16'h0000, c_out=1, ovf=0 (carry through all slices).
//  3. a=16'h7FFF, b=16'h0001 add -> 16'h8000, ovf=1, c_out=0; a=16'h8000, b=16'h0001 sub
//     -> 16'h7FFF, ovf=1, c_out=1; a=16'h0005, b=16'h0007 sub -> 16'hFFFE, c_out=0, ovf=0.
//  4. Backpressure: out_ready=0 for 3 cycles in DONE -> sum/c_out/ovf stable, in_ready=0,
//     in_valid pulse ignored; out_ready=1 -> IDLE next edge, in_ready=1.
//  5. rst_n=0 during 2nd RUN cycle -> next edge IDLE, out_valid=0, sum=0, in_ready=1; no result.
//  6. WORDS=1, WIDTH=8: a=8'hF0, b=8'h20 add -> sum=8'h10, c_out=1, out_valid after edge 1.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// Shared definitions for the multi-word CLA sequencer: FSM state codes and their width.
package cla_seq_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/cla_adder.sv
// Single WIDTH-bit carry-lookahead slice: generate/propagate terms feed the carry chain.
module cla_adder #(
    parameter int width = 4
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             c_in,
    output logic [width-1:0] sum,
    output logic             c_out
);

    logic [width-1:0] g;
    logic [width-1:0] p;
    logic [width:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < width; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum   = p ^ c[width-1:0];
    assign c_out = c[width];

endmodule

// File: rtl/cla_multiword_seq.sv
// Adds/subtracts two WIDTH*WORDS-bit operands over WORDS cycles through one shared
// cla_adder slice, LS slice first, carrying between cycles in a register.
module cla_multiword_seq
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   c_out,
    output logic                   ovf
);

    localparam int N     = WIDTH * WORDS;
    localparam int IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    state_t           state;
    logic [N-1:0]     a_reg;
    logic [N-1:0]     b_reg;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] slice_sum;
    logic             slice_c;

    cla_adder #(.width(WIDTH)) u_slice (
        .a     (a_reg[idx*WIDTH +: WIDTH]),
        .b     (b_reg[idx*WIDTH +: WIDTH]),
        .c_in  (carry),
        .sum   (slice_sum),
        .c_out (slice_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    sum[idx*WIDTH +: WIDTH] <= slice_sum;
                    carry                   <= slice_c;
                    if (idx == LAST) begin
                        c_out     <= slice_c;
                        // Overflow judged against the effective B, so subtraction needs no special case
                        ovf       <= (a_reg[N-1] == b_reg[N-1]) && (slice_sum[WIDTH-1] != a_reg[N-1]);
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    // Unused code 2'd3 behaves as IDLE
                    out_valid <= 1'b0;
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= sub ? ~b : b;
                        carry    <= sub;
                        idx      <= '0;
                        sum      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_RUN;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
